// File: rtl/seg7_pkg.sv
// Shared types and constants for the multiplexed seven-segment scanner.
// Segment vectors are ordered {g,f,e,d,c,b,a} and are active-low.
package seg7_pkg;

  // Scan controller states: dark, anode dead time, digit lit.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } scan_state_e;

  // All cathodes off.
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Width of the dead-time counter; BLANK_CYCLES is limited to 1..255.
  localparam int BLANK_CNT_W = 8;

  // Hex nibble to active-low segment pattern (lower-case b and d glyphs).
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] pattern;
    case (nib)
      4'h0:    pattern = 7'h40;
      4'h1:    pattern = 7'h79;
      4'h2:    pattern = 7'h24;
      4'h3:    pattern = 7'h30;
      4'h4:    pattern = 7'h19;
      4'h5:    pattern = 7'h12;
      4'h6:    pattern = 7'h02;
      4'h7:    pattern = 7'h78;
      4'h8:    pattern = 7'h00;
      4'h9:    pattern = 7'h10;
      4'hA:    pattern = 7'h08;
      4'hB:    pattern = 7'h03;
      4'hC:    pattern = 7'h46;
      4'hD:    pattern = 7'h21;
      4'hE:    pattern = 7'h06;
      4'hF:    pattern = 7'h0E;
      default: pattern = SEG_BLANK;
    endcase
    return pattern;
  endfunction

endpackage

// File: rtl/tick_sync.sv
// Brings the slow anode-rate toggle into the clk domain and flags its
// rising edges. Two flops resolve metastability, a third holds the previous
// synchronised level, so 'rise' is high for one cycle per input rise.
module tick_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  // Synchroniser chain followed by the edge-detect history flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rise = sync2_q & ~prev_q;

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed seven-segment display driver.
// Each digit is preceded by an anode-off dead time, then held lit until the
// next scan tick. The digit and decimal-point inputs are sampled once per
// frame (on entry to digit 0) so a frame never shows a mix of old and new
// values. All display outputs come straight from flops.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int BLANK_CYCLES = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          iclk,
  input  logic                          en,
  input  logic [4*NUM_DIGITS-1:0]       digits,
  input  logic [NUM_DIGITS-1:0]         dp,
  input  logic                          lz_suppress,
  output logic [NUM_DIGITS-1:0]         an,
  output logic [6:0]                    seg,
  output logic                          dp_n,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [IW-1:0]          LAST_IDX   = IW'(NUM_DIGITS - 1);
  localparam logic [BLANK_CNT_W-1:0] BLANK_LAST = BLANK_CNT_W'(BLANK_CYCLES - 1);

  scan_state_e state_q, state_d;

  logic [IW-1:0]           idx_q, idx_d;
  logic [IW-1:0]           idx_next_s;
  logic [BLANK_CNT_W-1:0]  cnt_q, cnt_d;

  logic [4*NUM_DIGITS-1:0] snap_digits_q, snap_digits_d;
  logic [NUM_DIGITS-1:0]   snap_dp_q, snap_dp_d;
  logic                    capture_s;

  logic [NUM_DIGITS-1:0]   lz_blank_s;
  logic                    lead_run_s;
  logic [3:0]              show_nib_s;

  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_n_q, dp_n_d;

  logic                    tick_s;

  tick_sync u_tick_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (iclk),
    .rise (tick_s)
  );

  // Next digit position, wrapping after the last digit.
  always_comb begin
    if (idx_q == LAST_IDX) begin
      idx_next_s = {IW{1'b0}};
    end else begin
      idx_next_s = idx_q + IW'(1);
    end
  end

  // A new frame starts whenever BLANK is entered for digit 0; that is the
  // only moment the inputs are sampled into the snapshot.
  always_comb begin
    capture_s = 1'b0;
    if (en && (state_q == IDLE)) begin
      capture_s = 1'b1;
    end else if (en && (state_q == SHOW) && tick_s && (idx_next_s == {IW{1'b0}})) begin
      capture_s = 1'b1;
    end else begin
      capture_s = 1'b0;
    end
  end

  // Scan state machine: dark / dead time / digit lit. Disable wins over a tick.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    if (!en) begin
      state_d = IDLE;
      idx_d   = {IW{1'b0}};
      cnt_d   = {BLANK_CNT_W{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          state_d = BLANK;
          idx_d   = {IW{1'b0}};
          cnt_d   = {BLANK_CNT_W{1'b0}};
        end
        BLANK: begin
          // Ticks are dropped here: the digit only advances from SHOW.
          if (cnt_q == BLANK_LAST) begin
            state_d = SHOW;
            cnt_d   = {BLANK_CNT_W{1'b0}};
          end else begin
            state_d = BLANK;
            cnt_d   = cnt_q + BLANK_CNT_W'(1);
          end
        end
        SHOW: begin
          if (tick_s) begin
            state_d = BLANK;
            idx_d   = idx_next_s;
            cnt_d   = {BLANK_CNT_W{1'b0}};
          end else begin
            state_d = SHOW;
            idx_d   = idx_q;
            cnt_d   = cnt_q;
          end
        end
        default: begin
          state_d = IDLE;
          idx_d   = {IW{1'b0}};
          cnt_d   = {BLANK_CNT_W{1'b0}};
        end
      endcase
    end
  end

  // Snapshot next value: load the live inputs at frame start, else hold.
  always_comb begin
    if (capture_s) begin
      snap_digits_d = digits;
      snap_dp_d     = dp;
    end else begin
      snap_digits_d = snap_digits_q;
      snap_dp_d     = snap_dp_q;
    end
  end

  // Leading-zero mask: digit i is blankable when it and every digit above it
  // hold a zero nibble with no decimal point. Digit 0 is always shown.
  always_comb begin
    lz_blank_s = {NUM_DIGITS{1'b0}};
    lead_run_s = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      lead_run_s    = lead_run_s & (snap_digits_q[4*i +: 4] == 4'h0) & ~snap_dp_q[i];
      lz_blank_s[i] = lead_run_s;
    end
  end

  // Output decode from the next state so the registered outputs line up with
  // the state they describe. The snapshot is stable whenever SHOW is entered
  // because BLANK always lasts at least one cycle.
  always_comb begin
    an_d       = {NUM_DIGITS{1'b1}};
    seg_d      = SEG_BLANK;
    dp_n_d     = 1'b1;
    show_nib_s = snap_digits_q[{idx_d, 2'b00} +: 4];
    if (state_d == SHOW) begin
      an_d[idx_d] = 1'b0;
      if (lz_suppress && lz_blank_s[idx_d]) begin
        seg_d  = SEG_BLANK;
        dp_n_d = 1'b1;
      end else begin
        seg_d  = hex_to_seg(show_nib_s);
        dp_n_d = ~snap_dp_q[idx_d];
      end
    end else begin
      an_d   = {NUM_DIGITS{1'b1}};
      seg_d  = SEG_BLANK;
      dp_n_d = 1'b1;
    end
  end

  // Controller state, dead-time counter and frame snapshot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      idx_q         <= {IW{1'b0}};
      cnt_q         <= {BLANK_CNT_W{1'b0}};
      snap_digits_q <= {(4*NUM_DIGITS){1'b0}};
      snap_dp_q     <= {NUM_DIGITS{1'b0}};
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      snap_digits_q <= snap_digits_d;
      snap_dp_q     <= snap_dp_d;
    end
  end

  // Display output flops; reset darkens the display without waiting for clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_q   <= {NUM_DIGITS{1'b1}};
      seg_q  <= SEG_BLANK;
      dp_n_q <= 1'b1;
    end else begin
      an_q   <= an_d;
      seg_q  <= seg_d;
      dp_n_q <= dp_n_d;
    end
  end

  assign an        = an_q;
  assign seg       = seg_q;
  assign dp_n      = dp_n_q;
  assign digit_idx = idx_q;

endmodule

// File: doc/seg7_scan.md
SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 8: number of multiplexed digits (range 2..8).
REQ-002 SHALL have parameter BLANK_CYCLES, default 4: anode-off dead time, in clk cycles, before each digit is shown (range 1..255).
REQ-003 SHALL have port clk  input  1: the only clock; all state is updated on its rising edge.
REQ-004 SHALL have port rst  input  1: reset, asynchronous and active-high.
REQ-005 SHALL have port iclk  input  1: scan toggle from the anode-rate divider; it is slow and square, and only its rising edges are significant.
REQ-006 SHALL have port en  input  1: scan enable; 0 = display dark.
REQ-007 SHALL have port digits  input  4*NUM_DIGITS: hex nibbles, digit 0 in bits [3:0].
REQ-008 SHALL have port dp  input  NUM_DIGITS: decimal-point request per digit, 1 = point lit.
REQ-009 SHALL have port lz_suppress  input  1: 1 = blank leading zeros.
REQ-010 SHALL have port an  output  NUM_DIGITS: anode select, active-low, one-hot-cold.
REQ-011 SHALL have port seg  output  7: cathodes {g,f,e,d,c,b,a}, active-low.
REQ-012 SHALL have port dp_n  output  1: decimal-point cathode, active-low.
REQ-013 SHALL have port digit_idx  output  $clog2(NUM_DIGITS): index of the digit being scanned.

Function
REQ-014 SHALL pass iclk through a 2-flop synchroniser, then a third flop for edge detection; a scan tick is sync=1 with previous=0, a 3-cycle latency after the iclk rise.
REQ-015 SHALL implement a state machine with states IDLE, BLANK and SHOW.
REQ-016 IDLE: an is all ones, seg is 7'h7F and dp_n is 1; when en=1 the machine SHALL go to BLANK with digit_idx=0.
REQ-017 BLANK: an is all ones; a counter SHALL run 0..BLANK_CYCLES-1, after which the machine goes to SHOW.
REQ-018 SHOW: exactly the an bit at digit_idx is 0; seg and dp_n carry the decoded snapshot digit; on a scan tick the machine SHALL go to BLANK with digit_idx incremented.
REQ-019 digit_idx SHALL wrap from NUM_DIGITS-1 to 0.
REQ-020 A scan tick arriving in BLANK or IDLE SHALL be ignored; it is not queued.
REQ-021 en=0 in any state SHALL force IDLE on the next clk; en=0 takes priority over a simultaneous tick.
REQ-022 digits and dp SHALL be captured into a snapshot register on each entry to BLANK with digit_idx=0, i.e. once per frame, so that a frame never tears.
REQ-023 The hex decode SHALL be 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E (hex values of seg).
REQ-024 With lz_suppress=1, digit i>0 SHALL be blanked (seg=7F, dp_n=1) when snapshot nibbles NUM_DIGITS-1..i are all zero and none of those digits has dp set; digit 0 is never suppressed.
REQ-025 an, seg and dp_n SHALL be registered outputs with no combinational path from any input.

Reset
REQ-026 On rst, state SHALL be IDLE; an all ones; seg 7'h7F; dp_n 1; digit_idx 0; snapshot, blank counter and synchroniser flops 0.
REQ-027 Asserting rst mid-scan SHALL darken the display within the same cycle, asynchronously; after rst deasserts, scanning restarts at digit 0 with a fresh snapshot.

Structure
REQ-028 The hex-to-seg table function, the state enum and the SEG_BLANK constant (7'h7F) SHALL live in package seg7_pkg.
REQ-029 The iclk synchroniser and edge detect SHALL be sub-module tick_sync (ports clk, rst, din, rise).
REQ-030 There SHALL be no other sub-modules.

Verification
REQ-031 Reset: rst=1 mid-SHOW -> an=FF, seg=7F and dp_n=1 with no clk edge required.
REQ-032 Scan order: NUM_DIGITS=8, BLANK_CYCLES=4, digits=32'h76543210, en=1, 10 iclk rises -> an sequence FE,FD,...,7F,FE,FD; each change is preceded by exactly 4 cycles of FF; seg while digit 2 is shown = 24.
REQ-033 Tearing: digits changed to 32'hFFFFFFFF while digit_idx=3 -> digits 3..7 of that frame still show the old values; the next frame shows seg=0E on all digits.
REQ-034 Suppression: digits=32'h00000305, dp=0, lz_suppress=1 -> digits 7..3 blank (7F); digit 2 = 30, digit 1 = 40, digit 0 = 12; setting dp[5]=1 -> digits 5..3 show 40.
REQ-035 Enable and tick races: en=0 in the same cycle as a tick -> IDLE and an=FF; an iclk rise during BLANK -> ignored, so the digit is held until the next rise.
REQ-036 Wrap: NUM_DIGITS=3 -> digit_idx sequence 0,1,2,0; an sequence 6,5,3,6.
